// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the pipe_stage register slice: state encodings,
// default NOP instruction, active levels and the saturating counter helper.
package pipe_stage_pkg;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  localparam logic [15:0] NOP_DEFAULT = 16'h0800;

  localparam logic Enable    = 1'b1;
  localparam logic RstEnable = 1'b1;

  typedef logic [15:0] perf_cnt_t;

  // Counters stick at all-ones rather than wrapping back to zero.
  function automatic perf_cnt_t sat_inc(input perf_cnt_t value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_stage_if.sv
// Valid/ready bus around a pipe_stage: upstream PC/instruction in, downstream out.
// The slave modport is the stage itself; master is the surrounding pipeline.
interface pipe_stage_if #(
  parameter int PC_W  = 16,
  parameter int INS_W = 16
);

  logic             up_valid;
  logic             up_ready;
  logic [PC_W-1:0]  up_pc;
  logic [INS_W-1:0] up_ins;

  logic             dn_valid;
  logic             dn_ready;
  logic [PC_W-1:0]  dn_pc;
  logic [INS_W-1:0] dn_ins;

  modport master (
    output up_valid, up_pc, up_ins, dn_ready,
    input  up_ready, dn_valid, dn_pc, dn_ins
  );

  modport slave (
    input  up_valid, up_pc, up_ins, dn_ready,
    output up_ready, dn_valid, dn_pc, dn_ins
  );

endinterface

// File: rtl/pipe_stage_perf.sv
// Saturating stall/bubble counter pair observing the downstream side of a
// pipe_stage; only instantiated when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_perf
  import pipe_stage_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      dn_valid,
  input  logic      dn_ready,
  output perf_cnt_t stall_cnt,
  output perf_cnt_t bubble_cnt
);

  logic stall_evt;
  logic bubble_evt;

  assign stall_evt  = dn_valid & ~dn_ready;
  assign bubble_evt = ~dn_valid & dn_ready;

  // Flush restarts the measurement window along with the pipeline contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (flush == Enable) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_evt) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (bubble_evt) begin
        bubble_cnt <= sat_inc(bubble_cnt);
      end
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// Parametrised PC/instruction pipeline register with a 2-entry skid buffer so
// up_ready is registered. Optional perf counters behind PIPE_STAGE_PERF_EN.
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int               PC_W    = 16,
  parameter int               INS_W   = 16,
  parameter logic [INS_W-1:0] NOP_INS = INS_W'(NOP_DEFAULT)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  pipe_stage_if.slave bus
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] bubble_cnt
`endif
);

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic             up_ready_q;

  logic [PC_W-1:0]  main_pc;
  logic [INS_W-1:0] main_ins;
  logic [PC_W-1:0]  skid_pc;
  logic [INS_W-1:0] skid_ins;

  logic             dn_valid_w;
  logic             up_fire;
  logic             dn_fire;

  logic             load_main_up;
  logic             load_main_skid;
  logic             load_skid;
  logic             clr_skid;

  // Only the two legal occupied encodings present data; the spare one reads as empty.
  assign dn_valid_w = (state == ONE) || (state == TWO);
  assign up_fire    = bus.up_valid & up_ready_q;
  assign dn_fire    = dn_valid_w & bus.dn_ready;

  assign bus.up_ready = up_ready_q;
  assign bus.dn_valid = dn_valid_w;
  assign bus.dn_pc    = dn_valid_w ? main_pc  : '0;
  assign bus.dn_ins   = dn_valid_w ? main_ins : NOP_INS;

  always_comb begin
    state_n        = state;
    load_main_up   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clr_skid       = 1'b0;

    if (flush == Enable) begin
      state_n  = EMPTY;
      clr_skid = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (up_fire) begin
            state_n      = ONE;
            load_main_up = 1'b1;
          end
        end
        ONE: begin
          if (up_fire && dn_fire) begin
            load_main_up = 1'b1;
          end else if (up_fire) begin
            state_n   = TWO;
            load_skid = 1'b1;
          end else if (dn_fire) begin
            state_n = EMPTY;
          end
        end
        TWO: begin
          if (dn_fire) begin
            state_n        = ONE;
            load_main_skid = 1'b1;
            clr_skid       = 1'b1;
          end
        end
        default: begin
          state_n  = EMPTY;
          clr_skid = 1'b1;
        end
      endcase
    end
  end

  // up_ready is registered from the next state, so downstream stalls never reach upstream combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state      <= EMPTY;
      up_ready_q <= 1'b1;
    end else begin
      state      <= state_n;
      up_ready_q <= (state_n != TWO);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      main_pc  <= '0;
      main_ins <= NOP_INS;
    end else if (load_main_up) begin
      main_pc  <= bus.up_pc;
      main_ins <= bus.up_ins;
    end else if (load_main_skid) begin
      main_pc  <= skid_pc;
      main_ins <= skid_ins;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      skid_pc  <= '0;
      skid_ins <= '0;
    end else if (load_skid) begin
      skid_pc  <= bus.up_pc;
      skid_ins <= bus.up_ins;
    end else if (clr_skid) begin
      skid_pc  <= '0;
      skid_ins <= '0;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_perf u_perf (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .dn_valid   (dn_valid_w),
    .dn_ready   (bus.dn_ready),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );
`endif

endmodule
